// File: rtl/dmac_evt_collector.sv
// Per-line DMA termination event collector: counts pulses, presents them as valid/ready events.
// Latency: a pulse is visible on evt_valid_o one cycle later; idle_o is registered (one cycle).
// Backpressure: events queue in a saturating per-line counter; overflow tracked when DMAC_EVT_COLLECTOR_OVF_EN is defined.
module dmac_evt_collector #(
    parameter int NB_CORES  = 8,
    parameter int CNT_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NB_CORES+1:0]   term_event_i,
    output logic [NB_CORES+1:0]   evt_valid_o,
    input  logic [NB_CORES+1:0]   evt_ready_i,
    output logic [NB_CORES+1:0]   evt_ovf_o,
    input  logic [NB_CORES+1:0]   ovf_clr_i,
    input  logic                  dma_busy_i,
    output logic                  idle_o
);

    localparam int NL = NB_CORES + 2;
    localparam logic [CNT_WIDTH-1:0] CMAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] cnt_q [NL];
    logic [CNT_WIDTH-1:0] cnt_d [NL];
    logic [NL-1:0]        hs;
    logic [NL-1:0]        drop;
    logic                 all_zero_d;
    logic                 idle_q;

    // Valid is decoded from the registered counter only, so no pulse reaches it combinationally.
    always_comb begin
        evt_valid_o = '0;
        for (int i = 0; i < NL; i++) begin
            evt_valid_o[i] = (cnt_q[i] != '0);
        end
    end

    assign hs = evt_valid_o & evt_ready_i;

    // Next counter value per line: pulse adds, handshake subtracts, both cancel; saturate at CMAX.
    always_comb begin
        drop       = '0;
        all_zero_d = 1'b1;
        for (int i = 0; i < NL; i++) begin
            cnt_d[i] = cnt_q[i];
            if (term_event_i[i] && !hs[i]) begin
                if (cnt_q[i] == CMAX) begin
                    drop[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + ONE;
                end
            end else if (hs[i] && !term_event_i[i]) begin
                cnt_d[i] = cnt_q[i] - ONE;
            end
            if (cnt_d[i] != '0) begin
                all_zero_d = 1'b0;
            end
        end
    end

    // Counter and idle registers; idle looks at the counters being written so it tracks them without extra lag.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NL; i++) begin
                cnt_q[i] <= '0;
            end
            idle_q <= 1'b0;
        end else begin
            for (int i = 0; i < NL; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            idle_q <= ~dma_busy_i & all_zero_d;
        end
    end

    assign idle_o = idle_q;

`ifdef DMAC_EVT_COLLECTOR_OVF_EN
    logic [NL-1:0] ovf_q;

    // Sticky overflow: a dropped pulse sets the flag; a set in the same cycle as a clear wins.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= (ovf_q & ~ovf_clr_i) | drop;
        end
    end

    assign evt_ovf_o = ovf_q;
`else
    // Overflow tracking compiled out: flags tied low, clear inputs have no effect.
    logic unused_ovf;
    assign unused_ovf = ^{ovf_clr_i, drop};
    assign evt_ovf_o  = '0;
`endif

endmodule
